// File: rtl/execute_cond_stage_pkg.sv
// Shared definitions for the ARMv3 execute-stage condition logic:
// condition codes, NZCV bit positions and flag-write enable bits.
package execute_cond_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/execute_cond_stage_cond_check.sv
// Combinational ARM condition-field evaluator: (cond, NZCV) -> pass/fail.
// Kept standalone so early branch resolution can reuse it.
module cond_check
    import execute_cond_stage_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       condEx_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        condEx_o = 1'b0;
        unique case (cond_i)
            COND_EQ: condEx_o = z;
            COND_NE: condEx_o = ~z;
            COND_CS: condEx_o = c;
            COND_CC: condEx_o = ~c;
            COND_MI: condEx_o = n;
            COND_PL: condEx_o = ~n;
            COND_VS: condEx_o = v;
            COND_VC: condEx_o = ~v;
            COND_HI: condEx_o = c & ~z;
            COND_LS: condEx_o = ~c | z;
            COND_GE: condEx_o = (n == v);
            COND_LT: condEx_o = (n != v);
            COND_GT: condEx_o = ~z & (n == v);
            COND_LE: condEx_o = z | (n != v);
            COND_AL: condEx_o = 1'b1;
            COND_NV: condEx_o = 1'b0;
            default: condEx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cond_stage.sv
// Decode->Execute pipeline boundary: registers the decoded control word,
// holds NZCV, and suppresses every state change of a condition-failed instruction.
module execute_cond_stage
    import execute_cond_stage_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic [3:0] CondD,
    input  logic       PCSD,
    input  logic       RegWD,
    input  logic       MemWD,
    input  logic       MemtoRegD,
    input  logic       ALUSrcD,
    input  logic [1:0] ALUControlD,
    input  logic [1:0] FlagWD,
    input  logic [3:0] ALUFlagsE,
    output logic       CondExE,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       MemtoRegE,
    output logic       ALUSrcE,
    output logic [1:0] ALUControlE,
    output logic [3:0] FlagsE
);

    logic [3:0] condE_q,       condE_d;
    logic       pcsE_q,        pcsE_d;
    logic       regWE_q,       regWE_d;
    logic       memWE_q,       memWE_d;
    logic       memtoRegE_q,   memtoRegE_d;
    logic       aluSrcE_q,     aluSrcE_d;
    logic [1:0] aluControlE_q, aluControlE_d;
    logic [1:0] flagWE_q,      flagWE_d;
    logic [3:0] flags_q,       flags_d;

    cond_check u_cond_check (
        .cond_i   (condE_q),
        .flags_i  (flags_q),
        .condEx_o (CondExE)
    );

    // A flush only has to kill the state-changing enables; the remaining
    // fields are don't-care in a bubble, so they simply follow Decode.
    always_comb begin
        condE_d       = condE_q;
        pcsE_d        = pcsE_q;
        regWE_d       = regWE_q;
        memWE_d       = memWE_q;
        memtoRegE_d   = memtoRegE_q;
        aluSrcE_d     = aluSrcE_q;
        aluControlE_d = aluControlE_q;
        flagWE_d      = flagWE_q;
        if (FlushE || !StallE) begin
            condE_d       = CondD;
            memtoRegE_d   = MemtoRegD;
            aluSrcE_d     = ALUSrcD;
            aluControlE_d = ALUControlD;
            pcsE_d        = FlushE ? 1'b0 : PCSD;
            regWE_d       = FlushE ? 1'b0 : RegWD;
            memWE_d       = FlushE ? 1'b0 : MemWD;
            flagWE_d      = FlushE ? 2'b00 : FlagWD;
        end
    end

    // Flags commit as the instruction leaves E, so a stall blocks the commit
    // but a flush of the incoming slot does not.
    always_comb begin
        flags_d = flags_q;
        if (!StallE && CondExE) begin
            if (flagWE_q[FLAGW_NZ]) begin
                flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
                flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
            end
            if (flagWE_q[FLAGW_CV]) begin
                flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
                flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            condE_q       <= 4'b0000;
            pcsE_q        <= 1'b0;
            regWE_q       <= 1'b0;
            memWE_q       <= 1'b0;
            memtoRegE_q   <= 1'b0;
            aluSrcE_q     <= 1'b0;
            aluControlE_q <= 2'b00;
            flagWE_q      <= 2'b00;
            flags_q       <= RESET_FLAGS;
        end else begin
            condE_q       <= condE_d;
            pcsE_q        <= pcsE_d;
            regWE_q       <= regWE_d;
            memWE_q       <= memWE_d;
            memtoRegE_q   <= memtoRegE_d;
            aluSrcE_q     <= aluSrcE_d;
            aluControlE_q <= aluControlE_d;
            flagWE_q      <= flagWE_d;
            flags_q       <= flags_d;
        end
    end

    assign PCSrcE      = pcsE_q  & CondExE;
    assign RegWriteE   = regWE_q & CondExE;
    assign MemWriteE   = memWE_q & CondExE;
    assign MemtoRegE   = memtoRegE_q;
    assign ALUSrcE     = aluSrcE_q;
    assign ALUControlE = aluControlE_q;
    assign FlagsE      = flags_q;

endmodule
